microwave_panel_ctrl: RTL and testbench
=======================================

Name: microwave_panel_ctrl

Overview:
Front-panel controller that drives the microwave timer/power core's command side. It turns user keys and the door switch into the core's time value `tin` and run request `r`. It watches the core's power flag `p` to detect cook start, stop and completion, and sounds a finish beep. Single clock domain; sits between the key debouncers and the timer core.

Parameters:
TW, 4, width of the time value (`tin`, set register).
MAX_TIME, 15, upper bound of the set time; must be ≤ 2^TW-1.
BEEP_CYCLES, 8, number of cycles `beep` is held high on completion.
START_TIMEOUT, 4, cycles allowed for `p` to rise after `r` rises.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
key_up  input  1  level, debounced; increment set time
key_down  input  1  level, debounced; decrement set time
key_start  input  1  level, debounced; start cooking
key_stop  input  1  level, debounced; stop / clear
door_open  input  1  level; 1 = door open
p  input  1  power flag from timer core (1 = magnetron on)
tin  output  TW  time value presented to the timer core
r  output  1  run request to the timer core
beep  output  1  completion buzzer
busy  output  1  high in RUN or DONE
fault  output  1  sticky; core failed to start

Behaviour:
- Reset: state IDLE, set_time=0, tin=0, r=0, beep=0, busy=0, fault=0, key edge registers=0. Reset mid-cook drops `r` on the next edge.
- Keys act on rising edge only: the previous level is registered and a press is `key & ~key_q`. A held key gives one press. Key priority when several press in the same cycle: stop > start > up > down.
- `tin` = set_time, registered. It changes only in IDLE, so it is stable while `r`=1.
- States IDLE, RUN, PAUSE, DONE, FAULT:
- IDLE:
  - up press: set_time+1, saturating at MAX_TIME.
  - down press: set_time-1, saturating at 0.
  - stop press: set_time=0.
  - start press with set_time≠0 and door_open=0: go to RUN, r=1 from the next cycle, start timeout counter cleared.
  - start press with set_time=0 or door open: ignored.
- RUN:
  - r=1.
  - If p=0 for START_TIMEOUT consecutive cycles since entry and p has never been seen high: r=0, fault=1, go to FAULT.
  - After p has been seen high, p falling with no stop or door event: completion, r=0, go to DONE.
  - door_open=1: r=0, go to PAUSE (door has priority over completion in the same cycle).
  - stop press: r=0, go to IDLE, set_time kept.
- PAUSE:
  - r=0.
  - start press with door closed: back to RUN with a fresh start-timeout window. The core resumes its own count; the panel does not reload.
  - stop press: go to IDLE, set_time=0.
- DONE:
  - beep=1 for exactly BEEP_CYCLES cycles, then go to IDLE with set_time=0.
  - stop press aborts the beep immediately and goes to IDLE.
- FAULT:
  - r=0, fault stays 1.
  - Only a stop press clears it: fault=0, go to IDLE, set_time=0.
- busy = (state==RUN) | (state==DONE).
- Up/down presses are ignored outside IDLE.

Test Plan:
- Reset, 3 up presses, start (door closed) → tin=3, r=1 next cycle; model core raises p within 2 cycles; p falls after 3 cycles → r=0, beep high for exactly 8 cycles, then IDLE, tin=0.
- 20 up presses → tin saturates at 15. 20 down presses → tin=0. Start with tin=0 → r stays 0.
- Cooking with p=1, door_open=1 → r=0 next cycle, state PAUSE. Door closed + start → r=1. Then stop → IDLE, tin=0.
- Start with p held at 0 → after 4 cycles r=0, fault=1. Start press is ignored. Stop press → fault=0, IDLE.
- key_start held high for 10 cycles → single start; start and stop pressed in the same cycle in IDLE → stop wins, r stays 0.
- rst asserted during RUN with p=1 → next edge: r=0, tin=0, beep=0, fault=0, busy=0.

Source files
------------

// File: rtl/microwave_panel_ctrl.sv
// Front-panel controller for the microwave timer/power core: turns keys and
// the door switch into the core's time value and run request, beeps on finish.
module microwave_panel_ctrl #(
  parameter int TW            = 4,
  parameter int MAX_TIME      = 15,
  parameter int BEEP_CYCLES   = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_start,
  input  logic          key_stop,
  input  logic          door_open,
  input  logic          p,
  output logic [TW-1:0] tin,
  output logic          r,
  output logic          beep,
  output logic          busy,
  output logic          fault
);

  localparam int CMAX = (START_TIMEOUT > BEEP_CYCLES) ? START_TIMEOUT : BEEP_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] time_reg, time_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          seen_reg, seen_next;
  logic [3:0]    keys, key_q_reg, press;

  // Bit order gives the priority order: stop, start, up, down.
  assign keys = {key_stop, key_start, key_up, key_down};

  for (genvar gi = 0; gi < 4; gi++) begin : g_edge
    assign press[gi] = keys[gi] & ~key_q_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      time_reg  <= '0;
      cnt_reg   <= '0;
      seen_reg  <= 1'b0;
      key_q_reg <= '0;
    end else begin
      state_reg <= state_next;
      time_reg  <= time_next;
      cnt_reg   <= cnt_next;
      seen_reg  <= seen_next;
      key_q_reg <= keys;
    end
  end

  // cnt_reg is shared: start-timeout window in RUN, beep length in DONE.
  always_comb begin
    state_next = state_reg;
    time_next  = time_reg;
    cnt_next   = cnt_reg;
    seen_next  = seen_reg;
    case (state_reg)
      IDLE: begin
        if (press[3]) begin
          time_next = '0;
        end else if (press[2]) begin
          if (time_reg != '0 && !door_open) begin
            state_next = RUN;
            cnt_next   = '0;
            seen_next  = 1'b0;
          end
        end else if (press[1]) begin
          if (time_reg < TW'(MAX_TIME)) time_next = time_reg + TW'(1);
        end else if (press[0]) begin
          if (time_reg != '0) time_next = time_reg - TW'(1);
        end
      end
      RUN: begin
        if (press[3]) begin
          state_next = IDLE;
        end else if (door_open) begin
          state_next = PAUSE;
        end else if (!seen_reg) begin
          if (p) begin
            seen_next = 1'b1;
          end else if (cnt_reg == CW'(START_TIMEOUT - 1)) begin
            state_next = FAULT;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end else if (!p) begin
          state_next = DONE;
          cnt_next   = '0;
        end
      end
      PAUSE: begin
        if (press[3]) begin
          state_next = IDLE;
          time_next  = '0;
        end else if (press[2] && !door_open) begin
          state_next = RUN;
          cnt_next   = '0;
          seen_next  = 1'b0;
        end
      end
      DONE: begin
        if (press[3] || cnt_reg == CW'(BEEP_CYCLES - 1)) begin
          state_next = IDLE;
          time_next  = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      FAULT: begin
        if (press[3]) begin
          state_next = IDLE;
          time_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tin   = time_reg;
  assign r     = (state_reg == RUN);
  assign beep  = (state_reg == DONE);
  assign busy  = (state_reg == RUN) | (state_reg == DONE);
  assign fault = (state_reg == FAULT);

endmodule

// File: tb/tb_microwave_panel_ctrl.sv
// Scoreboard bench for microwave_panel_ctrl: a behavioural panel + core model
// queues expected outputs per cycle; a monitor compares them after each edge.
module tb_microwave_panel_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_down = 1'b0, key_start = 1'b0, key_stop = 1'b0;
  logic       door_open = 1'b0;
  logic       p = 1'b0;
  logic [3:0] tin;
  logic       r, beep, busy, fault;

  always #5 clk = ~clk;

  microwave_panel_ctrl #(
    .TW(4), .MAX_TIME(15), .BEEP_CYCLES(8), .START_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .key_up(key_up), .key_down(key_down), .key_start(key_start), .key_stop(key_stop),
    .door_open(door_open), .p(p),
    .tin(tin), .r(r), .beep(beep), .busy(busy), .fault(fault)
  );

  typedef struct packed {
    logic [3:0] tin;
    logic       r;
    logic       beep;
    logic       busy;
    logic       fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Panel model: what the user-visible panel is doing, in plain terms.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3, M_FAULT = 4;
  int m_mode = M_IDLE;
  int m_time = 0;
  bit m_seen = 0;
  int m_low_cycles = 0;
  int m_beep_left = 0;
  bit prev_up = 0, prev_down = 0, prev_start = 0, prev_stop = 0;

  // Core model: p rises core_wait cycles after cooking starts, stays high core_left cycles.
  int cfg_delay = 1;
  int core_wait = 0;
  int core_left = 0;
  bit door_lvl  = 0;

  task automatic model_step(input bit rs, input bit u, input bit d, input bit st,
                            input bit sp, input bit dr, input bit pv);
    bit pu, pd, pst, psp;
    if (rs) begin
      m_mode = M_IDLE; m_time = 0; m_seen = 0; m_low_cycles = 0; m_beep_left = 0;
      prev_up = 0; prev_down = 0; prev_start = 0; prev_stop = 0;
      return;
    end
    pu = u && !prev_up; pd = d && !prev_down; pst = st && !prev_start; psp = sp && !prev_stop;
    prev_up = u; prev_down = d; prev_start = st; prev_stop = sp;
    case (m_mode)
      M_IDLE: begin
        if (psp) m_time = 0;
        else if (pst) begin
          if (m_time != 0 && !dr) begin
            m_mode = M_RUN; m_seen = 0; m_low_cycles = 0; core_wait = cfg_delay;
          end
        end
        else if (pu) m_time = (m_time + 1 > 15) ? 15 : m_time + 1;
        else if (pd) m_time = (m_time == 0) ? 0 : m_time - 1;
      end
      M_RUN: begin
        if (psp) m_mode = M_IDLE;
        else if (dr) m_mode = M_PAUSE;
        else if (!m_seen) begin
          if (pv) m_seen = 1;
          else begin
            m_low_cycles++;
            if (m_low_cycles >= 4) m_mode = M_FAULT;
          end
        end
        else if (!pv) begin
          m_mode = M_DONE; m_beep_left = 8;
        end
      end
      M_PAUSE: begin
        if (psp) begin m_mode = M_IDLE; m_time = 0; end
        else if (pst && !dr) begin
          m_mode = M_RUN; m_seen = 0; m_low_cycles = 0; core_wait = cfg_delay;
        end
      end
      M_DONE: begin
        if (psp) begin m_mode = M_IDLE; m_time = 0; end
        else begin
          m_beep_left--;
          if (m_beep_left == 0) begin m_mode = M_IDLE; m_time = 0; end
        end
      end
      default: begin
        if (psp) begin m_mode = M_IDLE; m_time = 0; end
      end
    endcase
  endtask

  // pm: 0 force p low, 1 force p high, 2 core model
  task automatic step(input bit rs, input bit u, input bit d, input bit st,
                      input bit sp, input int pm);
    bit   pv;
    exp_t e;
    @(negedge clk);
    if (pm == 0) pv = 0;
    else if (pm == 1) pv = 1;
    else if (m_mode != M_RUN) pv = 0;
    else if (core_wait > 0) begin core_wait--; pv = 0; end
    else if (core_left > 0) begin core_left--; pv = 1; end
    else pv = 0;
    rst = rs; key_up = u; key_down = d; key_start = st; key_stop = sp;
    door_open = door_lvl; p = pv;
    model_step(rs, u, d, st, sp, door_lvl, pv);
    e.tin   = 4'(m_time);
    e.r     = (m_mode == M_RUN);
    e.beep  = (m_mode == M_DONE);
    e.busy  = (m_mode == M_RUN) || (m_mode == M_DONE);
    e.fault = (m_mode == M_FAULT);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 2);
  endtask

  // k: 0 up, 1 down, 2 start, 3 stop; press for one cycle then release
  task automatic key(input int k);
    step(0, k == 0, k == 1, k == 2, k == 3, 2);
    step(0, 0, 0, 0, 0, 2);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        checks++;
        if ({tin, r, beep, busy, fault} !== e) begin
          errors++;
          $display("FAIL txn%0d outputs: got tin=%0d r=%0b beep=%0b busy=%0b fault=%0b, want tin=%0d r=%0b beep=%0b busy=%0b fault=%0b",
                   txn, tin, r, beep, busy, fault, e.tin, e.r, e.beep, e.busy, e.fault);
        end else begin
          $display("txn%0d ok tin=%0d r=%0b beep=%0b busy=%0b fault=%0b",
                   txn, tin, r, beep, busy, fault);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);

    // Basic cook: 3 ups, start, p up after 1 cycle for 3 cycles, beep 8, back to idle
    for (int i = 0; i < 3; i++) key(0);
    cfg_delay = 1; core_left = 3;
    key(2);
    idle(16);

    // Saturation both ways, then start with zero time
    for (int i = 0; i < 20; i++) key(0);
    for (int i = 0; i < 20; i++) key(1);
    key(2);
    idle(3);

    // Door pause/resume, then stop from pause
    for (int i = 0; i < 5; i++) key(0);
    cfg_delay = 0; core_left = 30;
    key(2);
    idle(3);
    door_lvl = 1;
    idle(3);
    key(2);
    door_lvl = 0;
    idle(1);
    key(2);
    idle(3);
    door_lvl = 1;
    idle(2);
    door_lvl = 0;
    key(3);
    idle(2);

    // Start timeout fault, ignored start, clear by stop
    for (int i = 0; i < 2; i++) key(0);
    cfg_delay = 99; core_left = 0;
    key(2);
    idle(6);
    key(2);
    idle(2);
    key(3);
    idle(2);

    // Held start gives one start; stop in RUN keeps set time
    for (int i = 0; i < 4; i++) key(0);
    cfg_delay = 1; core_left = 40;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 2);
    idle(2);
    key(3);
    idle(2);
    // start and stop together in IDLE: stop wins
    step(0, 0, 0, 1, 1, 2);
    idle(3);

    // Reset during RUN with p high
    for (int i = 0; i < 3; i++) key(0);
    cfg_delay = 0; core_left = 40;
    key(2);
    idle(3);
    step(1, 0, 0, 0, 0, 1);
    idle(3);

    // Randomized operation
    for (int n = 0; n < 500; n++) begin
      int rv;
      if (m_mode == M_IDLE) begin
        cfg_delay = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 3);
        core_left = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 29) == 0) door_lvl = ~door_lvl;
      rv = $urandom_range(0, 19);
      step($urandom_range(0, 199) == 0,
           rv == 0 || rv == 1 || rv == 2,
           rv == 3,
           rv == 4 || rv == 5 || (rv == 6 && $urandom_range(0, 1) == 1),
           rv == 7 || (rv == 4 && $urandom_range(0, 3) == 0),
           2);
    end

    // Drain the scoreboard
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
